// File: rtl/uart_burst_tx.sv
// Burst serialiser feeding async_transmitter: sends 1..MAX_BYTES bytes of a latched
// buffer, byte 0 first, pacing each byte on TxD_busy plus an inter-byte gap.
module uart_burst_tx #(
  parameter int MAX_BYTES   = 8,
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             byte_count,
  input  logic [8*MAX_BYTES-1:0] data_in,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy
);

  localparam int DATA_W = 8 * MAX_BYTES;
  localparam int IDX_W  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int ACK_W  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [3:0]       MAX_CNT  = 4'(MAX_BYTES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_SAT  = GAP_W'(GAP_CYCLES);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'((ACK_TIMEOUT > 2) ? ACK_TIMEOUT - 2 : 0);
  localparam logic [ACK_W-1:0] ACK_SAT  = ACK_W'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FIRE, S_ACK, S_DRAIN, S_GAP, S_NEXT, S_FIN
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_data;
  logic [3:0]         r_count;
  logic [IDX_W-1:0]   r_idx;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [ACK_W-1:0]   r_ack_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_tx_start;
  logic [7:0]         r_tx_data;

  logic [3:0]         w_count_clamped;
  logic               w_accept;
  logic               w_last;
  logic               w_ack_expired;
  logic               w_gap_expired;
  logic [DATA_W-1:0]  w_shifted;
  logic [7:0]         w_byte;

  assign w_count_clamped = (byte_count > MAX_CNT) ? MAX_CNT : byte_count;
  assign w_accept        = (r_state == S_IDLE) && start;
  assign w_last          = ((4'(r_idx) + 4'd1) == r_count);
  // The tx_start cycle is the first allowed cycle, so err lands ACK_TIMEOUT cycles after it.
  assign w_ack_expired   = (r_ack_cnt >= ACK_LAST);
  assign w_gap_expired   = (r_gap_cnt == GAP_LAST);

  // Byte 0 lives in the MSBs; shift the selected byte up to the top.
  assign w_shifted = r_data << {r_idx, 3'b000};
  assign w_byte    = w_shifted[DATA_W-1 -: 8];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (w_count_clamped == 4'd0) ? S_FIN : S_LOAD;
      S_LOAD:  w_state_nxt = S_FIRE;
      S_FIRE:  w_state_nxt = S_ACK;
      S_ACK: begin
        if (tx_busy)            w_state_nxt = S_DRAIN;
        else if (w_ack_expired) w_state_nxt = S_FIN;
      end
      S_DRAIN: if (!tx_busy) w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_NEXT;
      S_GAP:   if (w_gap_expired) w_state_nxt = S_NEXT;
      S_NEXT:  w_state_nxt = w_last ? S_FIN : S_LOAD;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Payload and length are held for the whole burst; no reset needed on data.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data  <= data_in;
      r_count <= w_count_clamped;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_gap_cnt  <= '0;
      r_ack_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt inside {S_LOAD, S_FIRE, S_ACK, S_DRAIN, S_GAP, S_NEXT});
      r_done     <= (w_state_nxt == S_FIN);
      r_tx_start <= (w_state_nxt == S_FIRE);

      if (w_accept) begin
        r_idx <= '0;
        r_err <= 1'b0;
      end else if (r_state == S_NEXT && !w_last) begin
        r_idx <= r_idx + IDX_W'(1);
      end

      if (r_state == S_LOAD) r_tx_data <= w_byte;

      if (r_state == S_FIRE)
        r_ack_cnt <= '0;
      else if (r_state == S_ACK && r_ack_cnt != ACK_SAT)
        r_ack_cnt <= r_ack_cnt + ACK_W'(1);

      if (r_state == S_DRAIN)
        r_gap_cnt <= '0;
      else if (r_state == S_GAP && r_gap_cnt != GAP_SAT)
        r_gap_cnt <= r_gap_cnt + GAP_W'(1);

      if (r_state == S_ACK && !tx_busy && w_ack_expired) r_err <= 1'b1;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_burst_tx.sv
// Directed bench for uart_burst_tx with a simple TxD_busy responder model.
module tb_uart_burst_tx;

  localparam int MAX_BYTES   = 8;
  localparam int GAP_CYCLES  = 16;
  localparam int ACK_TIMEOUT = 8;
  localparam int BUSY_LEN    = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  byte_count;
  logic [63:0] data_in;
  logic        busy, done, err, tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;

  logic        model_en;
  int          busy_cnt = 0;
  int          cyc = 0;
  int          n_done = 0;
  int          n_consec = 0;
  int          n_overlap = 0;
  logic        prev_start = 1'b0;
  logic [7:0]  q_bytes[$];
  int          q_times[$];

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc_start;
  int          done_cyc;
  int          base;
  int          dbase;

  logic [7:0]  exp_b [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
  localparam logic [63:0] D1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] D2 = 64'hFFEEDDCCBBAA9988;

  uart_burst_tx #(
    .MAX_BYTES(MAX_BYTES), .GAP_CYCLES(GAP_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .byte_count(byte_count), .data_in(data_in),
    .busy(busy), .done(done), .err(err), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for BUSY_LEN cycles starting the cycle after tx_start.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) busy_cnt <= BUSY_LEN;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = model_en && (busy_cnt != 0);

  always @(negedge clk) begin
    if (tx_start) begin
      q_bytes.push_back(tx_data);
      q_times.push_back(cyc);
      if (prev_start) n_consec++;
      if (tx_busy) n_overlap++;
    end
    if (done) n_done++;
    prev_start = tx_start;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [3:0] cnt, input logic [63:0] d);
    byte_count = cnt;
    data_in    = d;
    start      = 1'b1;
    cyc_start  = cyc;
    step(1);
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      step(1);
    end
    done_cyc = cyc;
    check(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; byte_count = 4'd0; data_in = '0; model_en = 1'b1;
    step(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_txstart", 64'(tx_start), 64'd0);
    check("rst_txdata", 64'(tx_data), 64'd0);
    rst = 1'b1;
    step(2);

    // Basic 8-byte burst
    base = q_bytes.size(); dbase = n_done;
    pulse(4'd8, D1);
    check("basic_busy_up", 64'(busy), 64'd1);
    wait_done(600, "basic_done_seen");
    check("basic_busy_at_done", 64'(busy), 64'd0);
    check("basic_err", 64'(err), 64'd0);
    check("basic_count", 64'(q_bytes.size() - base), 64'd8);
    check("basic_first_lat", 64'(q_times[base] - cyc_start), 64'd2);
    for (int i = 0; i < 8; i++) check($sformatf("basic_byte%0d", i), 64'(q_bytes[base+i]), 64'(exp_b[i]));
    for (int i = 1; i < 8; i++)
      check($sformatf("basic_space%0d", i), 64'(q_times[base+i] - q_times[base+i-1]), 64'd40);
    check("basic_done_lat", 64'(done_cyc - q_times[base+7]), 64'd39);
    check("basic_ndone", 64'(n_done - dbase), 64'd1);
    step(1);
    check("basic_done_pulse", 64'(done), 64'd0);

    // Partial burst of 3
    base = q_bytes.size();
    pulse(4'd3, D1);
    wait_done(300, "part_done_seen");
    check("part_count", 64'(q_bytes.size() - base), 64'd3);
    for (int i = 0; i < 3; i++) check($sformatf("part_byte%0d", i), 64'(q_bytes[base+i]), 64'(exp_b[i]));
    step(2);

    // Clamp 12 -> 8
    base = q_bytes.size();
    pulse(4'd12, D1);
    wait_done(600, "clamp_done_seen");
    check("clamp_count", 64'(q_bytes.size() - base), 64'd8);
    check("clamp_byte0", 64'(q_bytes[base]), 64'h01);
    check("clamp_byte7", 64'(q_bytes[base+7]), 64'hEF);
    step(2);

    // Zero length
    base = q_bytes.size();
    pulse(4'd0, D1);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    step(1);
    check("zero_done_drop", 64'(done), 64'd0);
    check("zero_busy2", 64'(busy), 64'd0);
    step(5);
    check("zero_nostart", 64'(q_bytes.size() - base), 64'd0);

    // Ack timeout: transmitter never acknowledges
    model_en = 1'b0;
    base = q_bytes.size();
    pulse(4'd4, D1);
    step(1);
    check("to_txstart", 64'(tx_start), 64'd1);
    step(7);
    check("to_err_early", 64'(err), 64'd0);
    step(1);
    check("to_err", 64'(err), 64'd1);
    check("to_done", 64'(done), 64'd1);
    step(25);
    check("to_err_sticky", 64'(err), 64'd1);
    check("to_one_start", 64'(q_bytes.size() - base), 64'd1);
    model_en = 1'b1;
    base = q_bytes.size();
    pulse(4'd1, D1);
    check("to_err_clear", 64'(err), 64'd0);
    wait_done(200, "to_good_done_seen");
    check("to_good_byte", 64'(q_bytes[base]), 64'h01);
    step(2);

    // start while busy is ignored
    base = q_bytes.size(); dbase = n_done;
    pulse(4'd4, D1);
    step(50);
    pulse(4'd8, D2);
    wait_done(400, "ign_done_seen");
    check("ign_count", 64'(q_bytes.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("ign_byte%0d", i), 64'(q_bytes[base+i]), 64'(exp_b[i]));
    check("ign_ndone", 64'(n_done - dbase), 64'd1);
    step(5);

    // Reset during DRAIN of byte 2
    base = q_bytes.size();
    pulse(4'd8, D1);
    begin
      bit reached;
      reached = 1'b0;
      for (int i = 0; i < 300; i++) begin
        if (q_bytes.size() - base >= 3) begin
          reached = 1'b1;
          break;
        end
        step(1);
      end
      check("rstm_reach_byte2", 64'(reached), 64'd1);
    end
    step(5);
    dbase = n_done;
    rst = 1'b0;
    #1;
    check("rstm_busy", 64'(busy), 64'd0);
    check("rstm_txstart", 64'(tx_start), 64'd0);
    check("rstm_txdata", 64'(tx_data), 64'd0);
    check("rstm_done", 64'(done), 64'd0);
    step(2);
    rst = 1'b1;
    step(60);
    check("rstm_no_more", 64'(q_bytes.size() - base), 64'd3);
    check("rstm_no_done", 64'(n_done - dbase), 64'd0);
    check("rstm_idle_busy", 64'(busy), 64'd0);
    base = q_bytes.size();
    pulse(4'd2, D1);
    wait_done(200, "rstm_restart_done");
    check("rstm_restart_count", 64'(q_bytes.size() - base), 64'd2);
    check("rstm_restart_b0", 64'(q_bytes[base]), 64'h01);
    check("rstm_restart_b1", 64'(q_bytes[base+1]), 64'h23);

    check("no_back_to_back", 64'(n_consec), 64'd0);
    check("no_start_while_busy", 64'(n_overlap), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_burst_tx.md
Name: uart_burst_tx

Overview:
- Transmit-side stage between the encode/decode buffers and async_transmitter.
- Serialises up to MAX_BYTES of a buffer, byte 0 first, into single-cycle TxD_start requests.
- Paces each byte on the transmitter's busy flag plus a programmable inter-byte gap.
- Replaces the hard-coded out_counter timing schedule with a handshake-driven burst of 1..MAX_BYTES bytes.

Parameters:
- MAX_BYTES, 8, largest burst length; data_in width is 8*MAX_BYTES.
- GAP_CYCLES, 16, idle clk cycles inserted after tx_busy falls before the next byte is started; 0 is legal.
- ACK_TIMEOUT, 8, clk cycles allowed for tx_busy to rise after a tx_start pulse.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- byte_count  in  4  number of bytes to send, 0..15; values above MAX_BYTES are clamped to MAX_BYTES.
- data_in  in  8*MAX_BYTES  payload; byte k = data_in[8*MAX_BYTES-1-8k -: 8], so byte 0 is the MSB byte.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at burst end.
- err  out  1  sticky ack-timeout flag; cleared by the next accepted start.
- tx_start  out  1  one-cycle pulse to async_transmitter TxD_start.
- tx_data  out  8  byte to transmit; stable from the tx_start cycle until tx_busy falls.
- tx_busy  in  1  async_transmitter TxD_busy.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, err and tx_start = 0; tx_data=0; byte index=0; counters=0.
- Reset asserted mid-burst aborts the burst immediately: tx_start drops the same instant, no done is issued, and no further bytes are sent after release.
- The burst is latched on start: data_in and the clamped byte_count are registered in IDLE when start=1. Later input changes do not affect the burst.
- start while busy=1 is ignored, with no queueing.
- start with byte_count=0: no tx_start is issued; done pulses on the cycle after start and busy stays 0.
- FSM states and transitions:
  - IDLE: on start with count>0, go to LOAD and set busy=1.
  - LOAD: tx_data <= byte[idx]; go to FIRE.
  - FIRE: tx_start=1 for exactly this cycle; the ack counter is cleared; go to ACK.
  - ACK: if tx_busy=1, go to DRAIN. If the ack counter reaches ACK_TIMEOUT, set err=1 and go to FIN, abandoning the remaining bytes.
  - DRAIN: wait for tx_busy=0. Then go to GAP if GAP_CYCLES>0, otherwise go straight to NEXT.
  - GAP: count GAP_CYCLES cycles, then go to NEXT.
  - NEXT: if idx==count-1 go to FIN; otherwise idx++ and go to LOAD.
  - FIN: done=1 for one cycle, busy=0; go to IDLE.
- Timing: with GAP_CYCLES=0, the first tx_start occurs 2 cycles after start is sampled (LOAD, then FIRE).
- Successive tx_start pulses are separated by at least the tx_busy-high duration + GAP_CYCLES + 3 cycles.
- tx_start is never high in two consecutive cycles, and never high while tx_busy=1.
- tx_busy already high at FIRE (transmitter still busy from an external source) counts as the ack; the FSM then waits for it to fall in DRAIN.
- Counter widths: idx is ceil(log2 MAX_BYTES) bits; the gap and ack counters are sized to their parameter and saturate, with no wrap.
- Outputs are registered, with no combinational path from tx_busy to tx_start.

Test Plan:
- Basic burst: data_in=64'h0123456789ABCDEF, byte_count=8, model tx_busy high for 20 cycles one cycle after each tx_start -> exactly 8 tx_start pulses carrying 01,23,45,67,89,AB,CD,EF in order. Consecutive pulses are ≥39 cycles apart (20+16+3). One done pulse, then busy=0, err=0.
- Partial and clamp: byte_count=3, then byte_count=12 -> first run sends 01,23,45 and then done. Second run sends all 8 bytes. No byte is ever sent from index ≥8.
- Zero length: byte_count=0 -> no tx_start; done pulses 1 cycle after start; busy stays 0.
- Ack timeout: hold tx_busy=0, byte_count=4 -> one tx_start pulse; err=1 exactly ACK_TIMEOUT cycles later, then done, no further tx_start. A subsequent good start clears err.
- start while busy: second start pulse mid-burst with a different data_in -> ignored; the original bytes complete unchanged.
- Reset mid-burst: assert rst=0 during DRAIN of byte 2 -> all outputs 0 immediately. After release: state is IDLE, no spurious tx_start, and the next start sends from byte 0.
